text_overlay: RTL and testbench

//  Pixel-pipeline stage between hdmi_compositor and the three tmds_encode instances.

---
 rtl/text_overlay_pkg.sv | 34 +++
 rtl/pipe_delay.sv | 25 ++
 rtl/text_overlay.sv | 125 ++++++++++++
 tb/tb_text_overlay.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/text_overlay_pkg.sv
// Shared video constants and pixel/glyph types for the text overlay stage.
package text_overlay_pkg;

  localparam int H_RESOLUTION   = 1280;
  localparam int V_RESOLUTION   = 720;
  localparam int FONT_W         = 8;
  localparam int FONT_H         = 8;
  localparam int TEXT_ROM_DEPTH = 80;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    rgb_t rgb;
  } video_t;

  typedef struct packed {
    logic       in_box;
    logic [2:0] gy;
    logic [2:0] gx;
  } glyph_pos_t;

  // Bit 7 of a glyph row is the leftmost pixel.
  function automatic logic glyph_bit(input logic [7:0] row, input logic [2:0] gx);
    return row[3'd7 - gx];
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with synchronous reset; DEPTH must be >= 1.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/text_overlay.sv
// Overlays a box of scaled 8x8 glyphs onto the compositor pixel stream.
// Fixed latency 2*ROM_LAT+2; sync/active/RGB stay aligned through the fetch.
module text_overlay
  import text_overlay_pkg::*;
#(
  parameter int          TEXT_X0    = 16,
  parameter int          TEXT_Y0    = 8,
  parameter int          TEXT_COLS  = 40,
  parameter int          TEXT_ROWS  = 2,
  parameter int          SCALE_LOG2 = 1,
  parameter int          ROM_LAT    = 1,
  parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
  parameter bit          BG_OPAQUE  = 1'b0,
  parameter logic [23:0] BG_RGB     = 24'h000000
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        active_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [10:0] x_coord,
  input  logic [9:0]  y_coord,
  input  logic [7:0]  pdata_r_in,
  input  logic [7:0]  pdata_g_in,
  input  logic [7:0]  pdata_b_in,
  output logic [6:0]  text_rom_addr,
  input  logic [7:0]  text_rom_data,
  output logic [9:0]  font_rom_addr,
  input  logic [7:0]  font_rom_data,
  output logic [7:0]  pdata_r,
  output logic [7:0]  pdata_g,
  output logic [7:0]  pdata_b,
  output logic        active_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int S     = SCALE_LOG2;
  localparam int BOX_W = (TEXT_COLS * FONT_W) << S;
  localparam int BOX_H = (TEXT_ROWS * FONT_H) << S;
  localparam int LAT   = 2 * ROM_LAT + 2;

  if (TEXT_COLS * TEXT_ROWS > TEXT_ROM_DEPTH) begin : g_bad_text_size
    $error("text box larger than text_rom");
  end

  // S0: box-relative coordinates; x<X0 wraps to a large value and falls outside.
  logic [11:0] rel_x_c, rel_y_c, rel_x, rel_y;
  logic        in_box_c, in_box;

  assign rel_x_c  = {1'b0, x_coord} - 12'(TEXT_X0);
  assign rel_y_c  = {2'b0, y_coord} - 12'(TEXT_Y0);
  assign in_box_c = active_in & enable
                  & (x_coord < 11'(H_RESOLUTION)) & (y_coord < 10'(V_RESOLUTION))
                  & (rel_x_c < 12'(BOX_W)) & (rel_y_c < 12'(BOX_H));

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      rel_x  <= '0;
      rel_y  <= '0;
      in_box <= 1'b0;
    end else begin
      rel_x  <= rel_x_c;
      rel_y  <= rel_y_c;
      in_box <= in_box_c;
    end
  end

  logic [11:0] col, row;
  glyph_pos_t  pos0, pos1, pos2;

  assign col  = rel_x >> (3 + S);
  assign row  = rel_y >> (3 + S);
  assign pos0 = '{in_box: in_box, gy: rel_y[S+2:S], gx: rel_x[S+2:S]};

  assign text_rom_addr = in_box ? 7'(int'(row) * TEXT_COLS + int'(col)) : '0;

  pipe_delay #(.WIDTH($bits(glyph_pos_t)), .DEPTH(ROM_LAT)) u_pos1 (
    .clk(pixel_clk), .rst(rst), .din(pos0), .dout(pos1)
  );

  assign font_rom_addr = pos1.in_box ? {text_rom_data[6:0], pos1.gy} : '0;

  pipe_delay #(.WIDTH($bits(glyph_pos_t)), .DEPTH(ROM_LAT)) u_pos2 (
    .clk(pixel_clk), .rst(rst), .din(pos1), .dout(pos2)
  );

  logic fg;
  assign fg = pos2.in_box & glyph_bit(font_rom_data, pos2.gx);

  // Video side path; the final output register supplies the last cycle.
  video_t vin, vdly, vout;
  assign vin = '{active: active_in, hsync: hsync_in, vsync: vsync_in,
                 rgb: '{r: pdata_r_in, g: pdata_g_in, b: pdata_b_in}};

  pipe_delay #(.WIDTH($bits(video_t)), .DEPTH(LAT-1)) u_vid (
    .clk(pixel_clk), .rst(rst), .din(vin), .dout(vdly)
  );

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      vout <= '0;
    end else begin
      vout.active <= vdly.active;
      vout.hsync  <= vdly.hsync;
      vout.vsync  <= vdly.vsync;
      if (fg)                       vout.rgb <= FG_RGB;
      else if (pos2.in_box && BG_OPAQUE) vout.rgb <= BG_RGB;
      else                          vout.rgb <= vdly.rgb;
    end
  end

  assign pdata_r    = vout.rgb.r;
  assign pdata_g    = vout.rgb.g;
  assign pdata_b    = vout.rgb.b;
  assign active_out = vout.active;
  assign hsync_out  = vout.hsync;
  assign vsync_out  = vout.vsync;

  // Low scale bits and the ignored code bit are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{rel_x, rel_y, text_rom_data[7]};

endmodule

// File: tb/tb_text_overlay.sv
// Scoreboard bench for text_overlay: default pass-through build and an opaque-background build.
module tb_text_overlay;

  localparam int LAT = 4;

  logic pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  logic        rst, enable, active_in, hsync_in, vsync_in;
  logic [10:0] x_coord;
  logic [9:0]  y_coord;
  logic [7:0]  r_in, g_in, b_in;

  logic [6:0] ta_a, ta_b;
  logic [9:0] fa_a, fa_b;
  logic [7:0] td_a, td_b, fd_a, fd_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       act_a, hs_a, vs_a, act_b, hs_b, vs_b;

  logic [7:0] text_mem [128];
  logic [7:0] font_mem [1024];

  always_ff @(posedge pixel_clk) begin
    td_a <= text_mem[ta_a];
    td_b <= text_mem[ta_b];
    fd_a <= font_mem[fa_a];
    fd_b <= font_mem[fa_b];
  end

  text_overlay u_dut (
    .pixel_clk(pixel_clk), .rst(rst), .enable(enable), .active_in(active_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .x_coord(x_coord), .y_coord(y_coord),
    .pdata_r_in(r_in), .pdata_g_in(g_in), .pdata_b_in(b_in),
    .text_rom_addr(ta_a), .text_rom_data(td_a), .font_rom_addr(fa_a), .font_rom_data(fd_a),
    .pdata_r(r_a), .pdata_g(g_a), .pdata_b(b_a),
    .active_out(act_a), .hsync_out(hs_a), .vsync_out(vs_a)
  );

  text_overlay #(.BG_OPAQUE(1'b1), .BG_RGB(24'h0000FF)) u_bg (
    .pixel_clk(pixel_clk), .rst(rst), .enable(enable), .active_in(active_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .x_coord(x_coord), .y_coord(y_coord),
    .pdata_r_in(r_in), .pdata_g_in(g_in), .pdata_b_in(b_in),
    .text_rom_addr(ta_b), .text_rom_data(td_b), .font_rom_addr(fa_b), .font_rom_data(fd_b),
    .pdata_r(r_b), .pdata_g(g_b), .pdata_b(b_b),
    .active_out(act_b), .hsync_out(hs_b), .vsync_out(vs_b)
  );

  typedef struct {
    logic [26:0] a;
    logic [26:0] b;
  } exp_t;

  exp_t       q[$];
  logic [9:0] font_exp_prev;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: box [16,656) x [8,40), 16x16 cells, 40 columns.
  function automatic logic [26:0] model(input logic act, hs, vs, en, input int x, y,
                                        input logic [23:0] pix, input bit opaque,
                                        output logic [6:0] taddr, output logic [9:0] faddr);
    logic       inb, bitv;
    logic [7:0] code, frow;
    logic [23:0] rgb;
    int col, row, gx, gy;
    inb   = act && en && x >= 16 && x < 656 && y >= 8 && y < 40;
    taddr = '0;
    faddr = '0;
    bitv  = 1'b0;
    if (inb) begin
      col   = (x - 16) / 16;
      row   = (y - 8) / 16;
      gx    = ((x - 16) / 2) % 8;
      gy    = ((y - 8) / 2) % 8;
      taddr = 7'(row * 40 + col);
      code  = text_mem[taddr];
      faddr = {code[6:0], 3'(gy)};
      frow  = font_mem[faddr];
      bitv  = frow[7 - gx];
    end
    if (inb && bitv)        rgb = 24'hFFFFFF;
    else if (inb && opaque) rgb = 24'h0000FF;
    else                    rgb = pix;
    return {act, hs, vs, rgb};
  endfunction

  task automatic step(input logic act, hs, vs, en, input int x, y, input logic [23:0] pix);
    exp_t e;
    logic [6:0] ta;
    logic [9:0] fa;
    active_in = act; hsync_in = hs; vsync_in = vs; enable = en;
    x_coord = 11'(x); y_coord = 10'(y);
    {r_in, g_in, b_in} = pix;
    e.a = model(act, hs, vs, en, x, y, pix, 1'b0, ta, fa);
    e.b = model(act, hs, vs, en, x, y, pix, 1'b1, ta, fa);
    q.push_back(e);
    @(posedge pixel_clk); #1;
    chk("text_rom_addr", 32'(ta_a), 32'(ta));
    chk("font_rom_addr", 32'(fa_a), 32'(font_exp_prev));
    font_exp_prev = fa;
    if (q.size() == LAT) begin
      e = q.pop_front();
      chk("out_passthru_build", 32'({act_a, hs_a, vs_a, r_a, g_a, b_a}), 32'(e.a));
      chk("out_opaque_build",   32'({act_b, hs_b, vs_b, r_b, g_b, b_b}), 32'(e.b));
    end
  endtask

  task automatic rst_step();
    rst = 1'b1;
    @(posedge pixel_clk); #1;
    chk("rst_out_a", 32'({act_a, hs_a, vs_a, r_a, g_a, b_a}), 32'd0);
    chk("rst_out_b", 32'({act_b, hs_b, vs_b, r_b, g_b, b_b}), 32'd0);
    chk("rst_addrs", 32'({ta_a, fa_a, ta_b, fa_b}), 32'd0);
  endtask

  // After release the flushed pipeline shows LAT-1 zero outputs.
  task automatic rst_release();
    exp_t z;
    z.a = '0;
    z.b = '0;
    rst = 1'b0;
    q.delete();
    repeat (LAT - 1) q.push_back(z);
    font_exp_prev = '0;
  endtask

  initial begin
    logic hs, vs;
    rst = 1'b1; enable = 1'b0; active_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    x_coord = '0; y_coord = '0; r_in = '0; g_in = '0; b_in = '0;
    font_exp_prev = '0;
    for (int i = 0; i < 128; i++)  text_mem[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) font_mem[i] = 8'($urandom);
    text_mem[0] = 8'h41;
    font_mem[{7'h41, 3'd0}] = 8'h18;

    rst_step();
    rst_step();
    rst_release();

    // Overlay disabled: pure delay, ROM addresses idle at 0.
    for (int x = 10; x <= 30; x++) step(1'b1, 1'b0, 1'b0, 1'b0, x, 8, 24'h123456);

    // Glyph 'A' row 0 across the first cell: x=22..25 foreground.
    for (int x = 10; x <= 35; x++) step(1'b1, 1'b0, 1'b0, 1'b1, x, 8, 24'h123456);

    // Box edges and addressing corners.
    step(1'b1, 1'b0, 1'b0, 1'b1, 640, 8,  24'h0A0B0C);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16,  24, 24'h0A0B0C);
    step(1'b1, 1'b0, 1'b0, 1'b1, 655, 39, 24'h0A0B0C);
    step(1'b1, 1'b0, 1'b0, 1'b1, 656, 8,  24'h0A0B0C);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16,  40, 24'h0A0B0C);
    step(1'b1, 1'b0, 1'b0, 1'b1, 15,  8,  24'h0A0B0C);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16,  7,  24'h0A0B0C);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1279, 719, 24'h0A0B0C);
    step(1'b0, 1'b0, 1'b0, 1'b1, 20,  8,  24'h0A0B0C);

    // Random traffic with sync/active edges and enable toggling mid-line.
    hs = 1'b0; vs = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 5) == 0) hs = ~hs;
      if ($urandom_range(0, 11) == 0) vs = ~vs;
      step(1'($urandom_range(0, 3) != 0), hs, vs, 1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 700)), int'($urandom_range(0, 50)), 24'($urandom));
    end

    // Reset mid-line flushes in-flight pixels.
    for (int x = 20; x < 26; x++) step(1'b1, 1'b1, 1'b0, 1'b1, x, 8, 24'h55AA55);
    rst_step();
    rst_step();
    rst_step();
    rst_release();
    for (int x = 26; x < 40; x++) step(1'b1, 1'b0, 1'b1, 1'b1, x, 9, 24'h55AA55);

    repeat (LAT) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 24'h000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
